daq_seq_ctrl: RTL and testbench



---
 rtl/daq_seq_pkg.sv | 44 ++++
 rtl/daq_seq_ctrl_timer.sv | 37 +++
 rtl/daq_seq_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_daq_seq_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/daq_seq_pkg.sv
// Shared definitions for the acquisition sequencer: state encoding, status
// word layout and the minimum re-arm gap.
package daq_seq_pkg;

    localparam logic [2:0] ST_IDLE_ENC     = 3'd0;
    localparam logic [2:0] ST_ARMED_ENC    = 3'd1;
    localparam logic [2:0] ST_WAIT_ACK_ENC = 3'd2;
    localparam logic [2:0] ST_HOLDOFF_ENC  = 3'd3;
    localparam logic [2:0] ST_ERROR_ENC    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = ST_IDLE_ENC,
        ST_ARMED    = ST_ARMED_ENC,
        ST_WAIT_ACK = ST_WAIT_ACK_ENC,
        ST_HOLDOFF  = ST_HOLDOFF_ENC,
        ST_ERROR    = ST_ERROR_ENC
    } state_t;

    localparam int BUSY_BIT     = 0;
    localparam int WAIT_ACK_BIT = 1;
    localparam int TMO_BIT      = 2;
    localparam int ABORT_BIT    = 3;
    localparam int CNT_LSB      = 16;

    localparam int MIN_GAP = 2;

    function automatic logic [31:0] make_status(
        input logic [15:0] cnt,
        input logic        aborted,
        input logic        tmo_err,
        input logic        wait_ack,
        input logic        busy
    );
        logic [31:0] st;
        st                 = '0;
        st[BUSY_BIT]       = busy;
        st[WAIT_ACK_BIT]   = wait_ack;
        st[TMO_BIT]        = tmo_err;
        st[ABORT_BIT]      = aborted;
        st[CNT_LSB +: 16]  = cnt;
        return st;
    endfunction

endpackage

// File: rtl/daq_seq_ctrl_timer.sv
// Loadable down-counter that stops at zero; zero is decoded from the register.
module daq_seq_timer #(
    parameter int W = 32
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/daq_seq_ctrl.sv
// Acquisition sequencer driving the axis_daq enable and ARM interrupt.
// Define DAQ_SEQ_TIMEOUT_EN to build the ARMED timeout and ERROR state.
module daq_seq_ctrl
    import daq_seq_pkg::*;
#(
    parameter int NUM_WIDTH = 16,
    parameter int TMR_WIDTH = 32
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 cmd_start,
    input  logic                 cmd_abort,
    input  logic                 buf_ack,
    input  logic [NUM_WIDTH-1:0] cfg_num,
    input  logic [TMR_WIDTH-1:0] cfg_holdoff,
    input  logic [TMR_WIDTH-1:0] cfg_timeout,
    input  logic [31:0]          daq_status_i,
    output logic                 meas_flag_o,
    output logic                 irq_o,
    output logic [31:0]          seq_status
);

    localparam logic [NUM_WIDTH-1:0] ONE_N = NUM_WIDTH'(1);
    localparam logic [TMR_WIDTH-1:0] ONE_T = TMR_WIDTH'(1);
    localparam logic [TMR_WIDTH-1:0] GAP_T = TMR_WIDTH'(MIN_GAP);

    state_t                 state_q, state_d;
    logic [NUM_WIDTH-1:0]   num_q, num_d;
    logic [TMR_WIDTH-1:0]   hold_q, hold_d;
    logic [NUM_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   tmo_err_q, tmo_err_d;
    logic                   abort_q, abort_d;
    logic                   meas_q, irq_q, irq_d;
    logic [31:0]            status_q, status_d;

    logic                   abort_go;
    logic                   start_go;
    logic                   done;
    logic                   hold_load;
    logic [TMR_WIDTH-1:0]   hold_clamp;
    logic [TMR_WIDTH-1:0]   hold_load_val;
    logic                   hold_zero;
    logic                   tmo_load;
    logic                   tmo_trip;

    assign done     = daq_status_i[0];
    assign abort_go = cmd_abort && (state_q != ST_IDLE);
    assign start_go = cmd_start && !abort_go &&
                      ((state_q == ST_IDLE) || (state_q == ST_ERROR));

    // The hold-off timer signals on reaching zero, so it is loaded one short
    // of the gap: ARMED is re-entered gap+1 cycles after the acknowledge.
    assign hold_clamp    = (hold_q < GAP_T) ? GAP_T : hold_q;
    assign hold_load_val = hold_clamp - ONE_T;

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        hold_d    = hold_q;
        cnt_d     = cnt_q;
        tmo_err_d = tmo_err_q;
        abort_d   = abort_q;
        irq_d     = 1'b0;
        hold_load = 1'b0;
        tmo_load  = 1'b0;

        if (abort_go) begin
            state_d = ST_IDLE;
            abort_d = 1'b1;
        end else if (start_go) begin
            num_d     = cfg_num;
            hold_d    = cfg_holdoff;
            cnt_d     = '0;
            tmo_err_d = 1'b0;
            abort_d   = 1'b0;
            tmo_load  = 1'b1;
            state_d   = ST_ARMED;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (done) begin
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + ONE_N;
                        end
                        irq_d   = 1'b1;
                        state_d = ST_WAIT_ACK;
                    end else if (tmo_trip) begin
                        tmo_err_d = 1'b1;
                        state_d   = ST_ERROR;
                    end
                end
                ST_WAIT_ACK: begin
                    if (buf_ack) begin
                        if ((num_q != '0) && (cnt_q == num_q)) begin
                            state_d = ST_IDLE;
                        end else begin
                            hold_load = 1'b1;
                            state_d   = ST_HOLDOFF;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_zero) begin
                        tmo_load = 1'b1;
                        state_d  = ST_ARMED;
                    end
                end
                ST_IDLE, ST_ERROR: ;
                default: state_d = ST_IDLE;
            endcase
        end

        status_d = make_status(16'(cnt_d), abort_d, tmo_err_d,
                               (state_d == ST_WAIT_ACK),
                               (state_d != ST_IDLE) && (state_d != ST_ERROR));
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            num_q     <= '0;
            hold_q    <= '0;
            cnt_q     <= '0;
            tmo_err_q <= 1'b0;
            abort_q   <= 1'b0;
            meas_q    <= 1'b0;
            irq_q     <= 1'b0;
            status_q  <= '0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
            tmo_err_q <= tmo_err_d;
            abort_q   <= abort_d;
            meas_q    <= (state_d == ST_ARMED);
            irq_q     <= irq_d;
            status_q  <= status_d;
        end
    end

    daq_seq_timer #(.W(TMR_WIDTH)) u_hold_timer (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .load     (hold_load),
        .load_val (hold_load_val),
        .en       (state_q == ST_HOLDOFF),
        .zero     (hold_zero)
    );

`ifdef DAQ_SEQ_TIMEOUT_EN
    logic [TMR_WIDTH-1:0] tmo_cfg_q;
    logic [TMR_WIDTH-1:0] tmo_load_val;
    logic                 tmo_zero;

    // A start loads the timer straight from the port, since the latched copy
    // only updates on the same edge.
    assign tmo_load_val = start_go ? cfg_timeout : tmo_cfg_q;
    assign tmo_trip     = (tmo_cfg_q != '0) && tmo_zero;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tmo_cfg_q <= '0;
        end else if (start_go) begin
            tmo_cfg_q <= cfg_timeout;
        end
    end

    daq_seq_timer #(.W(TMR_WIDTH)) u_tmo_timer (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .load     (tmo_load),
        .load_val (tmo_load_val),
        .en       (state_q == ST_ARMED),
        .zero     (tmo_zero)
    );
`else
    logic unused_tmo;
    assign tmo_trip   = 1'b0;
    assign unused_tmo = ^{cfg_timeout, tmo_load};
`endif

    logic unused_status;
    assign unused_status = ^daq_status_i[31:1];

    assign meas_flag_o = meas_q;
    assign irq_o       = irq_q;
    assign seq_status  = status_q;

endmodule

// File: tb/tb_daq_seq_ctrl.sv
// Scoreboard bench for daq_seq_ctrl: directed pulses, expected snapshots and
// irq events queued ahead of time and checked by an independent monitor.
module tb_daq_seq_ctrl;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cmd_start = 1'b0, cmd_abort = 1'b0, buf_ack = 1'b0;
    logic [15:0] cfg_num = '0;
    logic [31:0] cfg_holdoff = '0, cfg_timeout = '0, daq_status_i = '0;
    logic        meas_flag_o, irq_o;
    logic [31:0] seq_status;

    daq_seq_ctrl dut (
        .aclk         (clk),
        .aresetn      (aresetn),
        .cmd_start    (cmd_start),
        .cmd_abort    (cmd_abort),
        .buf_ack      (buf_ack),
        .cfg_num      (cfg_num),
        .cfg_holdoff  (cfg_holdoff),
        .cfg_timeout  (cfg_timeout),
        .daq_status_i (daq_status_i),
        .meas_flag_o  (meas_flag_o),
        .irq_o        (irq_o),
        .seq_status   (seq_status)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        meas;
        logic        irq;
        logic [31:0] st;
        string       nm;
    } exp_t;

    typedef struct {
        int cyc;
        int cnt;
    } irq_t;

    exp_t exp_q[$];
    irq_t irq_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] st(input int cnt, input bit ab, input bit tm,
                                       input bit wk, input bit bz);
        logic [15:0] c16;
        c16 = cnt[15:0];
        return {c16, 12'h000, ab, tm, wk, bz};
    endfunction

    task automatic expect_at(input int c, input logic m, input logic i,
                             input logic [31:0] s, input string nm);
        exp_t e;
        e.cyc = c; e.meas = m; e.irq = i; e.st = s; e.nm = nm;
        exp_q.push_back(e);
    endtask

    task automatic expect_range(input int c0, input int c1, input logic m,
                                input logic [31:0] s, input string nm);
        for (int c = c0; c <= c1; c++) expect_at(c, m, 1'b0, s, nm);
    endtask

    task automatic expect_irq(input int c, input int cnt);
        irq_t r;
        r.cyc = c; r.cnt = cnt;
        irq_q.push_back(r);
    endtask

    task automatic at(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // sel: 0 start, 1 abort, 2 ack, 3 done, 4 abort+done
    task automatic pulse(input int n, input int sel);
        at(n);
        case (sel)
            0: cmd_start = 1'b1;
            1: cmd_abort = 1'b1;
            2: buf_ack   = 1'b1;
            3: daq_status_i = 32'h0000_0001;
            default: begin cmd_abort = 1'b1; daq_status_i = 32'h0000_0001; end
        endcase
        at(n + 1);
        cmd_start = 1'b0; cmd_abort = 1'b0; buf_ack = 1'b0; daq_status_i = '0;
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (e.cyc < cyc) begin
                n_fail++;
                $display("FAIL %s: snapshot for cycle %0d not taken (now %0d)", e.nm, e.cyc, cyc);
            end else if (meas_flag_o !== e.meas || irq_o !== e.irq || seq_status !== e.st) begin
                n_fail++;
                $display("FAIL %s cyc=%0d: meas=%b irq=%b status=%h, required meas=%b irq=%b status=%h",
                         e.nm, cyc, meas_flag_o, irq_o, seq_status, e.meas, e.irq, e.st);
            end
        end
        if (irq_o === 1'b1) begin
            n_checks++;
            if (irq_q.size() == 0) begin
                n_fail++;
                $display("FAIL irq_unexpected cyc=%0d: irq=1 count=%0d, required no irq", cyc, seq_status[31:16]);
            end else begin
                irq_t r;
                r = irq_q.pop_front();
                if (r.cyc != cyc || int'(seq_status[31:16]) != r.cnt) begin
                    n_fail++;
                    $display("FAIL irq_event: cyc=%0d count=%0d, required cyc=%0d count=%0d",
                             cyc, seq_status[31:16], r.cyc, r.cnt);
                end
            end
        end
    end

    initial begin
        int b;
        #1;
        // Reset state
        expect_at(2, 1'b0, 1'b0, 32'h0, "reset_state");
        at(3);
        aresetn = 1'b1;

        // Single acquisition
        b = 5;
        cfg_num = 16'd1; cfg_holdoff = 32'd10; cfg_timeout = 32'd0;
        expect_at(b + 5, 1'b0, 1'b0, st(0, 0, 0, 0, 0), "single_idle");
        expect_range(b + 6, b + 50, 1'b1, st(0, 0, 0, 0, 1), "single_armed");
        expect_at(b + 51, 1'b0, 1'b1, st(1, 0, 0, 1, 1), "single_irq");
        expect_at(b + 52, 1'b0, 1'b0, st(1, 0, 0, 1, 1), "single_wait");
        expect_at(b + 60, 1'b0, 1'b0, st(1, 0, 0, 1, 1), "single_wait_end");
        expect_at(b + 61, 1'b0, 1'b0, st(1, 0, 0, 0, 0), "single_done_idle");
        expect_irq(b + 51, 1);
        pulse(b + 5, 0);
        pulse(b + 50, 3);
        pulse(b + 60, 2);

        // Three acquisitions, hold-off clamped to 2
        b = cyc + 2;
        cfg_num = 16'd3; cfg_holdoff = 32'd0;
        expect_at(b + 3, 1'b1, 1'b0, st(0, 0, 0, 0, 1), "three_arm");
        expect_at(b + 11, 1'b0, 1'b1, st(1, 0, 0, 1, 1), "three_irq1");
        expect_at(b + 15, 1'b0, 1'b0, st(1, 0, 0, 0, 1), "three_hold1");
        expect_at(b + 16, 1'b1, 1'b0, st(1, 0, 0, 0, 1), "three_rearm1");
        expect_at(b + 25, 1'b0, 1'b0, st(2, 0, 0, 0, 1), "three_hold2");
        expect_at(b + 26, 1'b1, 1'b0, st(2, 0, 0, 0, 1), "three_rearm2");
        expect_at(b + 34, 1'b0, 1'b0, st(3, 0, 0, 0, 0), "three_final");
        expect_at(b + 36, 1'b0, 1'b0, st(3, 0, 0, 0, 0), "three_stays_idle");
        expect_irq(b + 11, 1); expect_irq(b + 21, 2); expect_irq(b + 31, 3);
        pulse(b + 2, 0);
        pulse(b + 10, 3); pulse(b + 13, 2);
        pulse(b + 20, 3); pulse(b + 23, 2);
        pulse(b + 30, 3); pulse(b + 33, 2);
        at(b + 36);

        // Timeout
        b = cyc + 2;
        cfg_num = 16'd0; cfg_holdoff = 32'd0;
`ifdef DAQ_SEQ_TIMEOUT_EN
        cfg_timeout = 32'd100;
        expect_at(b + 103, 1'b1, 1'b0, st(0, 0, 0, 0, 1), "tmo_last_armed");
        expect_at(b + 104, 1'b0, 1'b0, st(0, 0, 1, 0, 0), "tmo_error");
        expect_at(b + 108, 1'b0, 1'b0, st(0, 0, 1, 0, 0), "tmo_error_hold");
        expect_at(b + 111, 1'b1, 1'b0, st(0, 0, 0, 0, 1), "tmo_restart");
        expect_at(b + 116, 1'b0, 1'b0, st(0, 1, 0, 0, 0), "tmo_abort");
        pulse(b + 2, 0);
        at(b + 105);
        cfg_timeout = 32'd0;
        pulse(b + 110, 0);
        pulse(b + 115, 1);
`else
        cfg_timeout = 32'd5;
        expect_at(b + 8, 1'b1, 1'b0, st(0, 0, 0, 0, 1), "notmo_t5");
        expect_at(b + 9, 1'b1, 1'b0, st(0, 0, 0, 0, 1), "notmo_t6");
        expect_at(b + 30, 1'b1, 1'b0, st(0, 0, 0, 0, 1), "notmo_late");
        expect_at(b + 32, 1'b0, 1'b0, st(0, 1, 0, 0, 0), "notmo_abort");
        pulse(b + 2, 0);
        pulse(b + 31, 1);
`endif
        cfg_timeout = 32'd0;

        // Abort and done in the same cycle while ARMED
        b = cyc + 2;
        cfg_num = 16'd0; cfg_holdoff = 32'd0;
        expect_at(b + 6, 1'b0, 1'b1, st(1, 0, 0, 1, 1), "ab_irq");
        expect_at(b + 14, 1'b1, 1'b0, st(1, 0, 0, 0, 1), "ab_rearmed");
        expect_at(b + 16, 1'b0, 1'b0, st(1, 1, 0, 0, 0), "ab_idle");
        expect_at(b + 17, 1'b0, 1'b0, st(1, 1, 0, 0, 0), "ab_no_irq");
        expect_irq(b + 6, 1);
        pulse(b + 2, 0);
        pulse(b + 5, 3);
        pulse(b + 8, 2);
        pulse(b + 15, 4);

        // Spurious inputs and config change after the latch
        b = cyc + 2;
        cfg_num = 16'd2; cfg_holdoff = 32'd3;
        expect_at(b + 3, 1'b1, 1'b0, st(0, 0, 0, 0, 1), "sp_arm");
        expect_at(b + 6, 1'b1, 1'b0, st(0, 0, 0, 0, 1), "sp_ack_ignored");
        expect_at(b + 8, 1'b1, 1'b0, st(0, 0, 0, 0, 1), "sp_start_ignored");
        expect_at(b + 11, 1'b0, 1'b1, st(1, 0, 0, 1, 1), "sp_irq1");
        expect_at(b + 13, 1'b0, 1'b0, st(1, 0, 0, 0, 1), "sp_latched_num");
        expect_at(b + 15, 1'b0, 1'b0, st(1, 0, 0, 0, 1), "sp_hold3");
        expect_at(b + 16, 1'b1, 1'b0, st(1, 0, 0, 0, 1), "sp_rearm");
        expect_at(b + 21, 1'b0, 1'b1, st(2, 0, 0, 1, 1), "sp_irq2");
        expect_at(b + 23, 1'b0, 1'b0, st(2, 0, 0, 1, 1), "sp_start_in_wait");
        expect_at(b + 24, 1'b0, 1'b0, st(2, 0, 0, 0, 0), "sp_idle");
        expect_irq(b + 11, 1); expect_irq(b + 21, 2);
        pulse(b + 2, 0);
        pulse(b + 5, 2);
        cfg_num = 16'd1;
        pulse(b + 6, 0);
        at(b + 7); daq_status_i = 32'hFFFF_FFFE;
        at(b + 8); daq_status_i = '0;
        pulse(b + 10, 3);
        pulse(b + 12, 2);
        pulse(b + 20, 3);
        pulse(b + 22, 0);
        pulse(b + 23, 2);

        // Asynchronous reset mid-acquisition
        b = cyc + 2;
        cfg_num = 16'd0;
        expect_at(b + 5, 1'b1, 1'b0, st(0, 0, 0, 0, 1), "rst_armed");
        expect_at(b + 6, 1'b0, 1'b0, 32'h0, "rst_async");
        expect_at(b + 9, 1'b0, 1'b0, 32'h0, "rst_after");
        pulse(b + 2, 0);
        at(b + 6); aresetn = 1'b0;
        at(b + 8); aresetn = 1'b1;
        at(b + 12);

        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++; n_fail++;
            $display("FAIL %s: snapshot for cycle %0d never checked", e.nm, e.cyc);
        end
        while (irq_q.size() > 0) begin
            irq_t r;
            r = irq_q.pop_front();
            n_checks++; n_fail++;
            $display("FAIL irq_missing: no irq seen, required at cycle %0d count %0d", r.cyc, r.cnt);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
